// File: rtl/alu_seq_unit.sv
// Registered ALU with valid/ready handshake; single-cycle logic/arith ops plus
// iterative shift-add multiply and restoring divide producing NZCV flags.
module alu_seq_unit #(
  parameter  int N   = 32,
  localparam int SHW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   ALUControl,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] resultado,
  output logic [3:0]   flags,
  output logic         div0
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam logic [3:0] OP_SUB  = 4'b0001, OP_MULT = 4'b0010, OP_DIV = 4'b0011,
                         OP_SLL  = 4'b0100, OP_SRL  = 4'b0101, OP_AND = 4'b0110,
                         OP_OR   = 4'b0111, OP_XOR  = 4'b1000, OP_NOT = 4'b1001;

  state_t         r_state, w_state_nxt;
  logic [SHW-1:0] r_cnt;
  logic [N-1:0]   r_acc, r_sh, r_mp, r_dv;
  logic           r_div0z;

  logic [N-1:0]   w_acc_cur, w_sh_cur, w_mp_cur, w_dv_cur;
  logic [N-1:0]   w_mul_acc, w_div_acc, w_div_q, w_rem_sub;
  logic [N:0]     w_rem_sh, w_add, w_sub;
  logic           w_ge;
  logic [N-1:0]   w_res;
  logic           w_c, w_v;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (in_valid) begin
        if (ALUControl == OP_MULT)     w_state_nxt = S_MUL;
        else if (ALUControl == OP_DIV) w_state_nxt = S_DIV;
        else                           w_state_nxt = S_DONE;
      end
      S_MUL, S_DIV: if (r_cnt == '0) w_state_nxt = S_DONE;
      S_DONE: if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The accept edge already performs the first iteration, so N-1 more remain.
  assign w_acc_cur = (r_state == S_IDLE) ? '0 : r_acc;
  assign w_sh_cur  = (r_state == S_IDLE) ? a  : r_sh;
  assign w_mp_cur  = (r_state == S_IDLE) ? b  : r_mp;
  assign w_dv_cur  = (r_state == S_IDLE) ? b  : r_dv;

  assign w_mul_acc = w_acc_cur + (w_mp_cur[0] ? w_sh_cur : '0);

  // Remainder stays below the divisor, so an N-bit subtract is exact; b==0 yields all ones.
  assign w_rem_sh  = {w_acc_cur, w_sh_cur[N-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, w_dv_cur});
  assign w_rem_sub = w_rem_sh[N-1:0] - w_dv_cur;
  assign w_div_acc = w_ge ? w_rem_sub : w_rem_sh[N-1:0];
  assign w_div_q   = {w_sh_cur[N-2:0], w_ge};

  assign w_add = {1'b0, a} + {1'b0, b};
  assign w_sub = {1'b0, a} - {1'b0, b};

  always_comb begin
    w_res = w_add[N-1:0];
    w_c   = w_add[N];
    w_v   = (a[N-1] == b[N-1]) && (w_add[N-1] != a[N-1]);
    case (ALUControl)
      OP_SUB: begin
        w_res = w_sub[N-1:0];
        w_c   = ~w_sub[N];
        w_v   = (a[N-1] != b[N-1]) && (w_sub[N-1] != a[N-1]);
      end
      OP_SLL: begin w_res = a << b[SHW-1:0]; w_c = 1'b0; w_v = 1'b0; end
      OP_SRL: begin w_res = a >> b[SHW-1:0]; w_c = 1'b0; w_v = 1'b0; end
      OP_AND: begin w_res = a & b;           w_c = 1'b0; w_v = 1'b0; end
      OP_OR:  begin w_res = a | b;           w_c = 1'b0; w_v = 1'b0; end
      OP_XOR: begin w_res = a ^ b;           w_c = 1'b0; w_v = 1'b0; end
      OP_NOT: begin w_res = ~a;              w_c = 1'b0; w_v = 1'b0; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resultado <= '0;
      flags     <= '0;
      div0      <= 1'b0;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_sh      <= '0;
      r_mp      <= '0;
      r_dv      <= '0;
      r_div0z   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          if (ALUControl == OP_MULT) begin
            r_acc <= w_mul_acc;
            r_sh  <= w_sh_cur << 1;
            r_mp  <= w_mp_cur >> 1;
            r_cnt <= SHW'(N-2);
          end else if (ALUControl == OP_DIV) begin
            r_acc   <= w_div_acc;
            r_sh    <= w_div_q;
            r_dv    <= b;
            r_div0z <= (b == '0);
            r_cnt   <= SHW'(N-2);
          end else begin
            resultado <= w_res;
            flags     <= {w_res[N-1], (w_res == '0), w_c, w_v};
            div0      <= 1'b0;
          end
        end
        S_MUL: begin
          r_acc <= w_mul_acc;
          r_sh  <= w_sh_cur << 1;
          r_mp  <= w_mp_cur >> 1;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            resultado <= w_mul_acc;
            flags     <= {w_mul_acc[N-1], (w_mul_acc == '0), 2'b00};
            div0      <= 1'b0;
          end
        end
        S_DIV: begin
          r_acc <= w_div_acc;
          r_sh  <= w_div_q;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            resultado <= w_div_q;
            flags     <= {w_div_q[N-1], (w_div_q == '0), 2'b00};
            div0      <= r_div0z;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed and random stimulus for alu_seq_unit (N=8) against an arithmetic reference model.
module tb_alu_seq_unit;
  localparam int N = 8;

  logic         clk, rst_n, in_valid, out_ready;
  logic         in_ready, out_valid, div0;
  logic [N-1:0] a, b, resultado;
  logic [3:0]   ALUControl, flags;
  int           total = 0, bad = 0;

  alu_seq_unit #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ALUControl(ALUControl), .out_valid(out_valid),
    .out_ready(out_ready), .resultado(resultado), .flags(flags), .div0(div0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [7:0] ma, input logic [7:0] mb, input logic [3:0] op,
                                output logic [7:0] r, output logic [3:0] f, output logic d,
                                output int lat);
    int ia, ib, sa, sb, s;
    logic c, v;
    ia = ma; ib = mb; sa = $signed(ma); sb = $signed(mb);
    c = 0; v = 0; d = 0; lat = 1;
    case (op)
      4'd1: begin r = 8'(ia - ib); c = (ia >= ib); s = sa - sb; v = (s > 127) || (s < -128); end
      4'd2: begin r = 8'(ia * ib); lat = N; end
      4'd3: begin r = (ib == 0) ? 8'hFF : 8'(ia / ib); d = (ib == 0); lat = N; end
      4'd4: r = 8'(ia << (ib % 8));
      4'd5: r = 8'(ia >> (ib % 8));
      4'd6: r = ma & mb;
      4'd7: r = ma | mb;
      4'd8: r = ma ^ mb;
      4'd9: r = 8'(255 - ia);
      default: begin r = 8'(ia + ib); c = (ia + ib) > 255; s = sa + sb; v = (s > 127) || (s < -128); end
    endcase
    f = {r[7], (r == 8'h00), c, v};
  endfunction

  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic [3:0] op,
                        input int hold);
    logic [7:0] er;
    logic [3:0] ef;
    logic       ed;
    int         el, lat;
    model(ta, tb_, op, er, ef, ed, el);
    @(negedge clk);
    a = ta; b = tb_; ALUControl = op; in_valid = 1; out_ready = 0;
    chk("in_ready_idle", {31'b0, in_ready}, 1);
    @(negedge clk);
    in_valid = 0; a = 8'($urandom); b = 8'($urandom); ALUControl = 4'($urandom);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("latency op=%0d", op), lat, el);
    chk($sformatf("result op=%0d a=%0h b=%0h", op, ta, tb_), {24'b0, resultado}, {24'b0, er});
    chk($sformatf("flags op=%0d", op), {28'b0, flags}, {28'b0, ef});
    chk($sformatf("div0 op=%0d", op), {31'b0, div0}, {31'b0, ed});
    for (int k = 0; k < hold; k++) begin
      in_valid = 1; a = 8'($urandom); b = 8'($urandom); ALUControl = 4'($urandom);
      @(negedge clk);
      chk("hold_result", {24'b0, resultado}, {24'b0, er});
      chk("hold_flags", {28'b0, flags}, {28'b0, ef});
      chk("hold_in_ready", {31'b0, in_ready}, 0);
      chk("hold_out_valid", {31'b0, out_valid}, 1);
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0; in_valid = 0;
    chk("post_handshake_valid", {31'b0, out_valid}, 0);
  endtask

  initial begin
    int seen;
    rst_n = 1; in_valid = 0; out_ready = 0; a = 0; b = 0; ALUControl = 0;

    // reset held two cycles while in_valid is high
    @(negedge clk);
    rst_n = 0; in_valid = 1; a = 8'h12; b = 8'h34; ALUControl = 4'd0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_result", {24'b0, resultado}, 0);
    chk("rst_flags", {28'b0, flags}, 0);
    chk("rst_div0", {31'b0, div0}, 0);
    rst_n = 1; in_valid = 0;
    @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 1);
    chk("rst_no_accept", {31'b0, out_valid}, 0);

    run_op(8'h7F, 8'h01, 4'd0, 0);
    chk("add_dir_res", {24'b0, resultado}, 32'h80);
    run_op(8'h05, 8'h05, 4'd1, 0);
    run_op(8'h0D, 8'h0B, 4'd2, 0);
    run_op(8'hC8, 8'h07, 4'd3, 0);
    run_op(8'h10, 8'h00, 4'd3, 0);
    run_op(8'hF0, 8'h0F, 4'd6, 0);
    run_op(8'h3C, 8'h55, 4'd8, 5);
    run_op(8'h09, 8'h11, 4'd2, 5);
    run_op(8'h80, 8'h80, 4'd0, 0);
    run_op(8'h80, 8'h01, 4'd1, 0);
    run_op(8'h00, 8'h01, 4'd1, 0);
    run_op(8'hA5, 8'h08, 4'd4, 0);
    run_op(8'hA5, 8'h00, 4'd5, 0);
    run_op(8'h5A, 8'h00, 4'd9, 0);
    run_op(8'hFF, 8'h01, 4'd15, 0);

    // reset three edges into a MULT discards it
    @(negedge clk);
    a = 8'h0D; b = 8'h0B; ALUControl = 4'd2; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    chk("mid_mult_reset_no_valid", seen, 0);
    chk("mid_mult_reset_result", {24'b0, resultado}, 0);
    run_op(8'h81, 8'h0A, 4'd4, 0);

    for (int i = 0; i < 60; i++)
      run_op(8'($urandom), (i % 9 == 0) ? 8'h00 : 8'($urandom), 4'($urandom_range(0, 15)),
             int'($urandom_range(0, 2)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
